// File: rtl/pipeline_ctrl_if.sv
// Handshake and control bundle between the pipeline datapath and its controller.
// The controller side uses the slave modport; the datapath or bench uses the master modport.
interface pipeline_ctrl_if;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        br_taken;
    logic        imem_resp;
    logic        dmem_req;
    logic        dmem_resp;
    logic        load_pc;
    logic        load_if_id;
    logic        load_id_ex;
    logic        load_ex_mem;
    logic        load_mem_wb;
    logic        bubble_id_ex;
    logic        flush_if_id;
    logic        imem_read;
    logic        dmem_en;
    logic [31:0] stall_count;

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd,
               br_taken, imem_resp, dmem_req, dmem_resp,
        output load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
               bubble_id_ex, flush_if_id, imem_read, dmem_en, stall_count
    );

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd,
               br_taken, imem_resp, dmem_req, dmem_resp,
        input  load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
               bubble_id_ex, flush_if_id, imem_read, dmem_en, stall_count
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline controller: memory-wait freeze, branch flush, load-use stall
// and a saturating count of cycles in which the PC did not advance.
module pipeline_ctrl (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_ctrl_if.slave        bus
);
    typedef enum logic {RUN, WAIT} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_i_done;
    logic        r_d_done;
    logic [31:0] r_stall_count;

    logic w_i_ok;
    logic w_d_ok;
    logic w_adv;
    logic w_hz;
    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_load_pc;
    logic w_load_if_id;
    logic w_load_id_ex;
    logic w_load_ex_mem;
    logic w_load_mem_wb;
    logic w_bubble_id_ex;
    logic w_flush_if_id;
    logic w_imem_read;
    logic w_dmem_en;

    assign w_i_ok    = bus.imem_resp | r_i_done;
    assign w_d_ok    = ~bus.dmem_req | bus.dmem_resp | r_d_done;
    assign w_adv     = w_i_ok & w_d_ok;
    assign w_rs1_hit = bus.id_use_rs1 & (bus.id_rs1 == bus.ex_rd);
    assign w_rs2_hit = bus.id_use_rs2 & (bus.id_rs2 == bus.ex_rd);
    assign w_hz      = bus.ex_mem_read & (bus.ex_rd != 5'd0) & (w_rs1_hit | w_rs2_hit);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (!w_adv) w_state_nxt = WAIT;
            WAIT:    if (w_adv)  w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    // Priority: reset, memory freeze, branch flush, load-use stall, normal advance.
    always_comb begin
        w_load_pc      = 1'b0;
        w_load_if_id   = 1'b0;
        w_load_id_ex   = 1'b0;
        w_load_ex_mem  = 1'b0;
        w_load_mem_wb  = 1'b0;
        w_bubble_id_ex = 1'b0;
        w_flush_if_id  = 1'b0;
        w_imem_read    = 1'b0;
        w_dmem_en      = 1'b0;
        if (rst) begin
            w_imem_read = ~r_i_done;
            w_dmem_en   = bus.dmem_req & ~r_d_done;
            if (w_adv) begin
                w_load_id_ex  = 1'b1;
                w_load_ex_mem = 1'b1;
                w_load_mem_wb = 1'b1;
                if (bus.br_taken) begin
                    w_load_pc      = 1'b1;
                    w_load_if_id   = 1'b1;
                    w_bubble_id_ex = 1'b1;
                    w_flush_if_id  = 1'b1;
                end else if (w_hz) begin
                    w_bubble_id_ex = 1'b1;
                end else begin
                    w_load_pc    = 1'b1;
                    w_load_if_id = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= RUN;
            r_i_done      <= 1'b0;
            r_d_done      <= 1'b0;
            r_stall_count <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_adv) begin
                r_i_done <= 1'b0;
                r_d_done <= 1'b0;
            end else begin
                if (bus.imem_resp)                 r_i_done <= 1'b1;
                if (bus.dmem_req && bus.dmem_resp) r_d_done <= 1'b1;
            end
            if (!w_load_pc && r_stall_count != 32'hFFFF_FFFF)
                r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign bus.load_pc      = w_load_pc;
    assign bus.load_if_id   = w_load_if_id;
    assign bus.load_id_ex   = w_load_id_ex;
    assign bus.load_ex_mem  = w_load_ex_mem;
    assign bus.load_mem_wb  = w_load_mem_wb;
    assign bus.bubble_id_ex = w_bubble_id_ex;
    assign bus.flush_if_id  = w_flush_if_id;
    assign bus.imem_read    = w_imem_read;
    assign bus.dmem_en      = w_dmem_en;
    assign bus.stall_count  = r_stall_count;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: a driver pushes expected outputs from a
// rule-level reference model, a monitor pops and compares them every cycle.
module tb_pipeline_ctrl;
    logic clk;
    logic rst;
    pipeline_ctrl_if u_if();

    pipeline_ctrl dut (.clk(clk), .rst(rst), .bus(u_if));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  ctrl;
        logic [31:0] cnt;
        int          tag;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   step_no = 0;

    // stimulus for the next cycle
    logic       s_rst, s_br, s_imem_resp, s_dmem_req, s_dmem_resp;
    logic       s_ex_mem_read, s_use1, s_use2;
    logic [4:0] s_rs1, s_rs2, s_ex_rd;

    // reference model state: which accesses of the current cycle group finished
    bit          m_fetch_done;
    bit          m_data_done;
    logic [31:0] m_cnt;

    task automatic idle_inputs();
        s_rst = 1'b1; s_br = 1'b0; s_imem_resp = 1'b1; s_dmem_req = 1'b0;
        s_dmem_resp = 1'b0; s_ex_mem_read = 1'b0; s_use1 = 1'b0; s_use2 = 1'b0;
        s_rs1 = 5'd0; s_rs2 = 5'd0; s_ex_rd = 5'd0;
    endtask

    task automatic step();
        exp_t e;
        bit adv, hz, lpc, lif, lid, lem, lmw, bub, fl, ird, den;
        @(negedge clk);
        rst                = s_rst;
        u_if.br_taken      = s_br;
        u_if.imem_resp     = s_imem_resp;
        u_if.dmem_req      = s_dmem_req;
        u_if.dmem_resp     = s_dmem_resp;
        u_if.ex_mem_read   = s_ex_mem_read;
        u_if.id_use_rs1    = s_use1;
        u_if.id_use_rs2    = s_use2;
        u_if.id_rs1        = s_rs1;
        u_if.id_rs2        = s_rs2;
        u_if.ex_rd         = s_ex_rd;

        {lpc, lif, lid, lem, lmw, bub, fl, ird, den} = '0;
        adv = (s_imem_resp || m_fetch_done) && (!s_dmem_req || s_dmem_resp || m_data_done);
        hz  = s_ex_mem_read && s_ex_rd != 0 &&
              ((s_use1 && s_rs1 == s_ex_rd) || (s_use2 && s_rs2 == s_ex_rd));
        if (s_rst) begin
            ird = !m_fetch_done;
            den = s_dmem_req && !m_data_done;
            if (adv && s_br)     {lpc, lif, lid, lem, lmw, bub, fl} = 7'b1111111;
            else if (adv && hz)  {lpc, lif, lid, lem, lmw, bub, fl} = 7'b0011110;
            else if (adv)        {lpc, lif, lid, lem, lmw, bub, fl} = 7'b1111100;
        end
        e.ctrl = {lpc, lif, lid, lem, lmw, bub, fl, ird, den};
        e.cnt  = m_cnt;
        e.tag  = step_no;
        q.push_back(e);
        step_no++;

        if (!s_rst) begin
            m_fetch_done = 0; m_data_done = 0; m_cnt = 0;
        end else begin
            if (!lpc && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (adv) begin
                m_fetch_done = 0; m_data_done = 0;
            end else begin
                if (s_imem_resp)                m_fetch_done = 1;
                if (s_dmem_req && s_dmem_resp)  m_data_done  = 1;
            end
        end
    endtask

    // monitor: sample combinational outputs 2 time units after inputs settle
    initial begin
        exp_t e;
        logic [8:0] act;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() != 0) begin
                e   = q.pop_front();
                act = {u_if.load_pc, u_if.load_if_id, u_if.load_id_ex, u_if.load_ex_mem,
                       u_if.load_mem_wb, u_if.bubble_id_ex, u_if.flush_if_id,
                       u_if.imem_read, u_if.dmem_en};
                n_tests++;
                if (act !== e.ctrl) begin
                    n_fail++;
                    $display("FAIL ctrl step %0d: got %b expected %b", e.tag, act, e.ctrl);
                end
                n_tests++;
                if (u_if.stall_count !== e.cnt) begin
                    n_fail++;
                    $display("FAIL stall_count step %0d: got %h expected %h",
                             e.tag, u_if.stall_count, e.cnt);
                end
            end
        end
    end

    initial begin
        m_fetch_done = 0; m_data_done = 0; m_cnt = 0;
        idle_inputs();
        s_rst = 1'b0;
        rst = 1'b0;
        u_if.br_taken = 0; u_if.imem_resp = 0; u_if.dmem_req = 0; u_if.dmem_resp = 0;
        u_if.ex_mem_read = 0; u_if.id_use_rs1 = 0; u_if.id_use_rs2 = 0;
        u_if.id_rs1 = 0; u_if.id_rs2 = 0; u_if.ex_rd = 0;
        repeat (3) step();

        // steady advance
        idle_inputs();
        repeat (10) step();

        // load-use on rs2, then the bubble removes the load
        s_ex_mem_read = 1; s_ex_rd = 5; s_rs2 = 5; s_use2 = 1;
        step();
        s_ex_mem_read = 0;
        step();
        s_ex_mem_read = 1; s_ex_rd = 0; s_rs2 = 0;
        step();
        idle_inputs();

        // data wait three cycles, fetch returns on cycle 1 only
        for (int c = 0; c < 4; c++) begin
            s_dmem_req  = 1;
            s_imem_resp = (c == 1);
            s_dmem_resp = (c == 3);
            step();
        end
        idle_inputs();
        step();

        // branch and hazard together
        s_br = 1; s_ex_mem_read = 1; s_ex_rd = 7; s_rs1 = 7; s_use1 = 1;
        step();
        idle_inputs();

        // branch held through a freeze
        s_br = 1; s_imem_resp = 0;
        repeat (2) step();
        s_imem_resp = 1;
        step();
        idle_inputs();
        step();

        // reset during a freeze with the data flag set
        s_dmem_req = 1; s_dmem_resp = 1; s_imem_resp = 0;
        step();
        s_dmem_resp = 0;
        step();
        s_rst = 0;
        step();
        idle_inputs();
        s_dmem_req = 1; s_dmem_resp = 0;
        step();
        idle_inputs();
        step();

        // saturation near the top of the counter
        @(negedge clk);
        force dut.r_stall_count = 32'hFFFF_FFFE;
        #1 release dut.r_stall_count;
        m_cnt = 32'hFFFF_FFFE;
        s_imem_resp = 0;
        repeat (4) step();
        idle_inputs();
        step();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            s_rst         = ($urandom_range(0, 39) != 0);
            s_br          = ($urandom_range(0, 99) < 15);
            s_imem_resp   = ($urandom_range(0, 99) < 70);
            s_dmem_req    = ($urandom_range(0, 99) < 40);
            s_dmem_resp   = ($urandom_range(0, 99) < 50);
            s_ex_mem_read = ($urandom_range(0, 1) == 1);
            s_use1        = ($urandom_range(0, 1) == 1);
            s_use2        = ($urandom_range(0, 1) == 1);
            s_rs1         = 5'($urandom_range(0, 3));
            s_rs2         = 5'($urandom_range(0, 3));
            s_ex_rd       = 5'($urandom_range(0, 3));
            step();
        end

        repeat (3) @(negedge clk);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Port clk  in  1  single clock; all state updates on rising edge.
REQ-002 Port rst  in  1  reset, synchronous, active-low (0 = reset).
REQ-003 Port id_rs1  in  5  rs1 index of the instruction in ID.
REQ-004 Port id_rs2  in  5  rs2 index of the instruction in ID.
REQ-005 Port id_use_rs1  in  1  ID instruction reads rs1.
REQ-006 Port id_use_rs2  in  1  ID instruction reads rs2.
REQ-007 Port ex_mem_read  in  1  control word held in ID_EX is a load.
REQ-008 Port ex_rd  in  5  rd of the control word held in ID_EX.
REQ-009 Port br_taken  in  1  EX resolved a taken branch or jump.
REQ-010 Port imem_resp  in  1  instruction memory returns data this cycle.
REQ-011 Port dmem_req  in  1  MEM stage holds a load or store.
REQ-012 Port dmem_resp  in  1  data memory completes this cycle.
REQ-013 Ports load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb  out  1 each  pipeline register load enables.
REQ-014 Port bubble_id_ex  out  1  ID_EX captures an all-zero control word (NOP).
REQ-015 Port flush_if_id  out  1  IF_ID captures a NOP.
REQ-016 Port imem_read  out  1  fetch request enable.
REQ-017 Port dmem_en  out  1  data request enable, gated dmem_req.
REQ-018 Port stall_count  out  32  cycles with load_pc = 0 since reset.

Function
REQ-019 Internal state: FSM {RUN, WAIT}, flags i_done and d_done, stall_count register.
REQ-020 i_ok = imem_resp | i_done; d_ok = ~dmem_req | dmem_resp | d_done; adv = i_ok & d_ok.
REQ-021 adv = 0: all five load_* = 0, bubble_id_ex = 0, flush_if_id = 0 (full freeze).
REQ-022 Freeze: imem_resp sets i_done, dmem_resp with dmem_req sets d_done; set flags hold until adv.
REQ-023 adv = 1: i_done and d_done clear on the next edge.
REQ-024 imem_read = ~i_done; dmem_en = dmem_req & ~d_done; an access that has completed is never re-issued.
REQ-025 FSM transitions: RUN->WAIT on adv = 0; WAIT->RUN on adv = 1; otherwise hold.
REQ-026 Load-use hazard hz = ex_mem_read & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
REQ-027 adv & br_taken: all loads = 1, flush_if_id = 1, bubble_id_ex = 1; hz is ignored.
REQ-028 adv & ~br_taken & hz: load_pc = 0, load_if_id = 0, load_id_ex = 1, bubble_id_ex = 1, load_ex_mem = 1, load_mem_wb = 1.
REQ-029 adv & ~br_taken & ~hz: all loads = 1, no bubble, no flush.
REQ-030 Priority, highest first: reset, memory freeze, branch flush, load-use stall, normal advance.
REQ-031 hz stalls exactly one cycle; the bubble clears ex_mem_read in ID_EX, so hz drops on the next cycle.
REQ-032 br_taken held during a freeze acts only in the first adv cycle.
REQ-033 stall_count increments on every non-reset edge with load_pc = 0; it saturates at 0xFFFFFFFF without wrapping.
REQ-034 Outputs other than stall_count are combinational from inputs and state; no extra latency.

Reset
REQ-035 rst = 0 at an edge: FSM = RUN, i_done = 0, d_done = 0, stall_count = 0.
REQ-036 While rst = 0: all load_* = 0, bubble_id_ex = 0, flush_if_id = 0, imem_read = 0, dmem_en = 0.
REQ-037 Reset asserted mid-freeze discards the pending flags; the first cycle after release is RUN with no flags set.

Verification
REQ-038 imem_resp = 1 and dmem_req = 0 every cycle for 10 cycles -> all loads = 1 each cycle, stall_count stays 0.
REQ-039 ex_mem_read = 1, ex_rd = 5, id_rs2 = 5, id_use_rs2 = 1 -> one cycle with load_pc = 0, load_if_id = 0, bubble_id_ex = 1; stall_count = 1; repeat with ex_rd = 0 -> no stall.
REQ-040 dmem_req = 1 with dmem_resp after 3 cycles and imem_resp on cycle 1 only -> freeze for 3 cycles, imem_read = 0 after cycle 1, adv on cycle 3 (0-indexed), stall_count = 3.
REQ-041 br_taken and hz in the same adv cycle -> flush_if_id = 1, bubble_id_ex = 1, load_pc = 1.
REQ-042 rst = 0 during a freeze with d_done = 1 -> after release: d_done = 0, FSM = RUN, stall_count = 0.
REQ-043 Force stall_count to 0xFFFFFFFE and hold a freeze for 3 cycles -> reads 0xFFFFFFFF and holds.
